dmem_access_unit: RTL



---
 rtl/dmem_access_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// Data-memory responder: runs LW/LH/LHU/LB/LBU/SW/SH/SB against an
// internal single-port word RAM with a req/done handshake.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req             access request, sampled only in IDLE
//   MemRead[2:0]    load code (101 = no load)
//   MemWrite[1:0]   store code (11 = no store)
//   addr, wdata     byte address and store data
//   rdata           load result while done=1, else 0
//   done, err       completion pulse and its error flag
//   busy            high in every state except IDLE
module dmem_access_unit #(
   parameter int ADDR_W = 12,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [2:0]        MemRead,
   input  logic [1:0]        MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata,
   output logic              done,
   output logic              err,
   output logic              busy
);

   localparam int DEPTH = 1 << (ADDR_W - 2);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   state_e            state_q;
   size_e             size_q;
   logic              uns_q;
   logic              load_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   word_q;
   logic [XLEN-1:0]   rdata_q;
   logic              done_q;
   logic              err_q;
   logic              busy_q;

   logic [XLEN-1:0]   mem_q [DEPTH];

   logic [ADDR_W-3:0] idx;
   logic [XLEN-1:0]   ram_rd;
   logic              mem_we;

   logic              ld_ok, no_ld, st_ok;
   logic              is_none, is_ill, is_ld, is_st;
   logic              ld_uns_d, mis_d;
   size_e             ld_sz_d, st_sz_d, sz_d;
   logic [15:0]       half_sel;
   logic [7:0]        byte_sel;
   logic [XLEN-1:0]   rd_fmt_d;
   logic [XLEN-1:0]   wr_word_d;

   assign idx    = addr_q[ADDR_W-1:2];
   assign ram_rd = mem_q[idx];
   // Write enable gated by rst_n so an abandoned RMW never lands.
   assign mem_we = rst_n && (state_q == WR);

   assign rdata = rdata_q;
   assign done  = done_q;
   assign err   = err_q;
   assign busy  = busy_q;

   // Request decode; the four classes are mutually exclusive.
   always_comb begin
      ld_ok    = (MemRead <= 3'd4);
      no_ld    = (MemRead == 3'd5);
      st_ok    = (MemWrite != 2'b11);
      is_none  = no_ld && !st_ok;
      is_ill   = (MemRead[2:1] == 2'b11) || (ld_ok && st_ok);
      is_ld    = ld_ok && !st_ok;
      is_st    = no_ld && st_ok;
      ld_uns_d = (MemRead == 3'b010) || (MemRead == 3'b100);
      ld_sz_d  = SZ_B;
      case (MemRead)
         3'b000:         ld_sz_d = SZ_W;
         3'b001, 3'b010: ld_sz_d = SZ_H;
         default:        ld_sz_d = SZ_B;
      endcase
      st_sz_d = SZ_B;
      case (MemWrite)
         2'b00:   st_sz_d = SZ_W;
         2'b01:   st_sz_d = SZ_H;
         default: st_sz_d = SZ_B;
      endcase
      sz_d  = st_ok ? st_sz_d : ld_sz_d;
      mis_d = ((sz_d == SZ_W) && (addr[1:0] != 2'b00)) ||
              ((sz_d == SZ_H) && addr[0]);
   end

   // Load formatting and sub-word store merge.
   always_comb begin
      half_sel  = addr_q[1] ? ram_rd[31:16] : ram_rd[15:0];
      byte_sel  = ram_rd[{addr_q[1:0], 3'b000} +: 8];
      rd_fmt_d  = ram_rd;
      wr_word_d = word_q;
      case (size_q)
         SZ_W: begin
            rd_fmt_d  = ram_rd;
            wr_word_d = wdata_q;
         end
         SZ_H: begin
            rd_fmt_d = {{16{half_sel[15] & ~uns_q}}, half_sel};
            if (addr_q[1])
               wr_word_d[31:16] = wdata_q[15:0];
            else
               wr_word_d[15:0] = wdata_q[15:0];
         end
         default: begin
            rd_fmt_d = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            wr_word_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[idx] <= wr_word_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         load_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  size_q  <= sz_d;
                  uns_q   <= ld_uns_d;
                  load_q  <= is_ld;
                  unique case (1'b1)
                     is_none: state_q <= IDLE;
                     is_ill: begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b1;
                     end
                     is_ld, is_st: begin
                        busy_q <= 1'b1;
                        if (mis_d) begin
                           state_q <= DONE;
                           done_q  <= 1'b1;
                           err_q   <= 1'b1;
                        end else if (is_st && sz_d == SZ_W) begin
                           state_q <= WR;
                        end else begin
                           state_q <= RD;
                        end
                     end
                  endcase
               end
            end
            RD: begin
               if (load_q) begin
                  rdata_q <= rd_fmt_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  word_q  <= ram_rd;
                  state_q <= WR;
               end
            end
            WR: begin
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
               rdata_q <= '0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
